// File: rtl/calc_pkg.sv
// Shared key codes, operator encodings and sequencer state encoding for the
// calculator keypad front end.
package calc_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_A    = 2'b01;
  localparam logic [1:0] OP_B    = 2'b10;
  localparam logic [1:0] OP_STAR = 2'b11;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } state_e;

endpackage

// File: rtl/key_class_decode.sv
// Combinational classification of a translated key code into its key class
// and, for operator keys, the matching op_code.
module key_class_decode
  import calc_pkg::*;
(
  input  logic [3:0] key_code_i,
  output logic       is_digit_o,
  output logic       is_op_o,
  output logic       is_clr_o,
  output logic       is_equ_o,
  output logic       is_bksp_o,
  output logic [1:0] op_code_o
);

  always_comb begin
    is_digit_o = 1'b0;
    is_op_o    = 1'b0;
    is_clr_o   = 1'b0;
    is_equ_o   = 1'b0;
    is_bksp_o  = 1'b0;
    op_code_o  = OP_NONE;
    case (key_code_i)
      KEY_A:    begin is_op_o = 1'b1; op_code_o = OP_A;    end
      KEY_B:    begin is_op_o = 1'b1; op_code_o = OP_B;    end
      KEY_STAR: begin is_op_o = 1'b1; op_code_o = OP_STAR; end
      KEY_C:    is_clr_o  = 1'b1;
      KEY_D:    is_equ_o  = 1'b1;
      KEY_HASH: is_bksp_o = 1'b1;
      default:  is_digit_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad-entry sequencer: accumulates two BCD operands and an operator, then
// offers them to the ALU. Handshake: a transfer completes on any rising edge where calc_valid & calc_ready.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  input  logic                 calc_ready,
  output logic                 calc_valid,
  output logic [4*NDIGITS-1:0] op_a,
  output logic [4*NDIGITS-1:0] op_b,
  output logic [1:0]           op_code,
  output logic [4*NDIGITS-1:0] disp_bcd,
  output logic                 disp_sel,
  output logic                 overflow_err,
  output logic                 key_ignored,
  output logic [1:0]           dbg_state_o
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          is_digit, is_op, is_clr, is_equ, is_bksp;
  logic [1:0]    key_op;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]    op_q, op_d;
  logic          ovf_q, ovf_d, ign_q, ign_d;
  logic          clr_key, do_clear;

  key_class_decode u_decode (
    .key_code_i (key_code),
    .is_digit_o (is_digit),
    .is_op_o    (is_op),
    .is_clr_o   (is_clr),
    .is_equ_o   (is_equ),
    .is_bksp_o  (is_bksp),
    .op_code_o  (key_op)
  );

  assign clr_key  = key_valid & is_clr;
  // Clear key and a completed transfer land in the same cleared S_A state.
  assign do_clear = clr_key | ((state_q == S_OUT) & calc_ready);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    ign_d   = 1'b0;
    if (!clr_key) begin
      case (state_q)
        S_A: if (key_valid) begin
          if (is_digit) begin
            if (cnt_a_q == CNT_MAX) begin
              ovf_d = 1'b1;
              ign_d = 1'b1;
            end else if (cnt_a_q == '0 && key_code == 4'h0) begin
              ign_d = 1'b1;
            end else begin
              a_d     = (a_q << 4) | W'(key_code);
              cnt_a_d = cnt_a_q + CNT_ONE;
            end
          end else if (is_bksp) begin
            if (cnt_a_q == '0) ign_d = 1'b1;
            else begin
              a_d     = a_q >> 4;
              cnt_a_d = cnt_a_q - CNT_ONE;
            end
          end else if (is_op) begin
            op_d    = key_op;
            state_d = S_B;
          end else if (is_equ) begin
            ign_d = 1'b1;
          end
        end
        S_B: if (key_valid) begin
          if (is_digit) begin
            if (cnt_b_q == CNT_MAX) begin
              ovf_d = 1'b1;
              ign_d = 1'b1;
            end else if (cnt_b_q == '0 && key_code == 4'h0) begin
              ign_d = 1'b1;
            end else begin
              b_d     = (b_q << 4) | W'(key_code);
              cnt_b_d = cnt_b_q + CNT_ONE;
            end
          end else if (is_bksp) begin
            if (cnt_b_q == '0) ign_d = 1'b1;
            else begin
              b_d     = b_q >> 4;
              cnt_b_d = cnt_b_q - CNT_ONE;
            end
          end else if (is_op) begin
            // Operator may only be swapped while B is still empty.
            if (cnt_b_q == '0) op_d = key_op;
            else ign_d = 1'b1;
          end else if (is_equ) begin
            if (cnt_b_q == '0) ign_d = 1'b1;
            else state_d = S_OUT;
          end
        end
        S_OUT: if (key_valid) ign_d = 1'b1;
        default: state_d = S_A;
      endcase
    end
    if (do_clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = OP_NONE;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= OP_NONE;
      ovf_q   <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      ign_q   <= ign_d;
    end
  end

  assign calc_valid   = (state_q == S_OUT);
  assign op_a         = a_q;
  assign op_b         = b_q;
  assign op_code      = op_q;
  assign disp_sel     = (state_q != S_A);
  assign disp_bcd     = disp_sel ? b_q : a_q;
  assign overflow_err = ovf_q;
  assign key_ignored  = ign_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with NDIGITS=4.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        calc_ready = 1'b0;
  logic        calc_valid;
  logic [15:0] op_a, op_b, disp_bcd;
  logic [1:0]  op_code, dbg_state;
  logic        disp_sel, overflow_err, key_ignored;

  int n_checks = 0;
  int n_fail   = 0;

  calc_key_sequencer #(.NDIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .calc_ready   (calc_ready),
    .calc_valid   (calc_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_code      (op_code),
    .disp_bcd     (disp_bcd),
    .disp_sel     (disp_sel),
    .overflow_err (overflow_err),
    .key_ignored  (key_ignored),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, {31'd0, calc_valid}, 32'd0);
    chk({tag, "_op_a"}, {16'd0, op_a}, 32'd0);
    chk({tag, "_op_b"}, {16'd0, op_b}, 32'd0);
    chk({tag, "_op"}, {30'd0, op_code}, 32'd0);
    chk({tag, "_disp"}, {16'd0, disp_bcd}, 32'd0);
    chk({tag, "_sel"}, {31'd0, disp_sel}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow_err}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'(S_A));
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk_cleared("rst");
    chk("rst_ign", {31'd0, key_ignored}, 32'd0);
    rst_n = 1'b1;

    // 1: 12 A 3 = , then handshake
    press(4'h1);
    press(4'h2);
    chk("t1_disp_a", {16'd0, disp_bcd}, 32'h0012);
    chk("t1_sel_a", {31'd0, disp_sel}, 32'd0);
    press(KEY_A);
    chk("t1_state_b", {30'd0, dbg_state}, 32'(S_B));
    press(4'h3);
    press(KEY_D);
    chk("t1_valid", {31'd0, calc_valid}, 32'd1);
    chk("t1_op_a", {16'd0, op_a}, 32'h0012);
    chk("t1_op_b", {16'd0, op_b}, 32'h0003);
    chk("t1_op", {30'd0, op_code}, 32'h1);
    chk("t1_disp_b", {16'd0, disp_bcd}, 32'h0003);
    chk("t1_sel_b", {31'd0, disp_sel}, 32'd1);
    @(negedge clk);
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    chk_cleared("t1_done");

    // 2: overflow on fifth digit, backspace keeps flag, C clears
    press(4'h9);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    chk("t2_ign_6", {31'd0, key_ignored}, 32'd0);
    press(4'h5);
    chk("t2_op_a", {16'd0, op_a}, 32'h9876);
    chk("t2_ovf", {31'd0, overflow_err}, 32'd1);
    chk("t2_ign_5", {31'd0, key_ignored}, 32'd1);
    @(negedge clk);
    chk("t2_ign_drop", {31'd0, key_ignored}, 32'd0);
    press(KEY_HASH);
    chk("t2_bksp", {16'd0, op_a}, 32'h0987);
    chk("t2_ovf_kept", {31'd0, overflow_err}, 32'd1);
    press(KEY_C);
    chk("t2_ovf_clr", {31'd0, overflow_err}, 32'd0);
    chk("t2_disp_clr", {16'd0, disp_bcd}, 32'd0);
    chk("t2_ign_c", {31'd0, key_ignored}, 32'd0);

    // 3: leading zeros, backspace, backspace on empty
    press(4'h0);
    chk("t3_ign_z1", {31'd0, key_ignored}, 32'd1);
    press(4'h0);
    chk("t3_ign_z2", {31'd0, key_ignored}, 32'd1);
    chk("t3_disp_z", {16'd0, disp_bcd}, 32'd0);
    press(4'h4);
    chk("t3_ign_4", {31'd0, key_ignored}, 32'd0);
    chk("t3_disp_4", {16'd0, disp_bcd}, 32'h0004);
    press(KEY_HASH);
    chk("t3_ign_bk", {31'd0, key_ignored}, 32'd0);
    press(4'h7);
    chk("t3_disp_7", {16'd0, disp_bcd}, 32'h0007);
    press(4'h0);
    chk("t3_inner_zero", {16'd0, disp_bcd}, 32'h0070);
    press(KEY_C);
    press(KEY_HASH);
    chk("t3_ign_bk0", {31'd0, key_ignored}, 32'd1);
    press(KEY_D);
    chk("t3_ign_eq_a", {31'd0, key_ignored}, 32'd1);
    chk("t3_state_a", {30'd0, dbg_state}, 32'(S_A));

    // 4: operator replacement while B empty, no chaining
    press(4'h5);
    press(KEY_A);
    press(KEY_B);
    chk("t4_op_b", {30'd0, op_code}, 32'h2);
    chk("t4_ign_rep", {31'd0, key_ignored}, 32'd0);
    press(KEY_STAR);
    chk("t4_op_star", {30'd0, op_code}, 32'h3);
    press(KEY_D);
    chk("t4_ign_eq", {31'd0, key_ignored}, 32'd1);
    chk("t4_valid0", {31'd0, calc_valid}, 32'd0);
    press(4'h2);
    press(KEY_A);
    chk("t4_ign_chain", {31'd0, key_ignored}, 32'd1);
    chk("t4_op_kept", {30'd0, op_code}, 32'h3);
    press(KEY_D);
    chk("t4_valid", {31'd0, calc_valid}, 32'd1);
    chk("t4_op_a", {16'd0, op_a}, 32'h0005);
    chk("t4_op_b_val", {16'd0, op_b}, 32'h0002);
    chk("t4_op_final", {30'd0, op_code}, 32'h3);

    // 5: S_OUT holds while not ready, then C with ready
    press(4'h3);
    chk("t5_ign_3", {31'd0, key_ignored}, 32'd1);
    press(KEY_A);
    chk("t5_ign_a", {31'd0, key_ignored}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("t5_hold", {10'd0, calc_valid, op_code, op_a[7:0], op_b[7:0], disp_sel},
          {10'd0, 1'b1, 2'b11, 8'h05, 8'h02, 1'b1});
    end
    @(negedge clk);
    key_valid  = 1'b1;
    key_code   = KEY_C;
    calc_ready = 1'b1;
    @(negedge clk);
    key_valid  = 1'b0;
    calc_ready = 1'b0;
    chk_cleared("t5_done");
    chk("t5_ign", {31'd0, key_ignored}, 32'd0);

    // 6: async reset mid-cycle in S_B, then in S_OUT
    press(4'h1);
    press(KEY_A);
    press(4'h2);
    chk("t6_pre_state", {30'd0, dbg_state}, 32'(S_B));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_cleared("t6_rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    press(4'h4);
    press(KEY_B);
    press(4'h6);
    press(KEY_D);
    chk("t6_pre_valid", {31'd0, calc_valid}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_cleared("t6_rst_out");
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
